// File: rtl/sea_battle_pkg.sv
// Shared sea-battle definitions: grid geometry, scan codes, cell encodings and FSM states.
// Consumed by the shot controller, cursor controller and board renderer.
package sea_battle_pkg;

  localparam int GRID_X     = 320;
  localparam int GRID_Y     = 50;
  localparam int CELL_SIZE  = 30;
  localparam int GRID_N     = 10;
  localparam int SHIP_CELLS = 20;

  localparam int GRID_X_END = GRID_X + GRID_N * CELL_SIZE;
  localparam int GRID_Y_END = GRID_Y + GRID_N * CELL_SIZE;

  localparam logic [7:0] KEY_FIRE = 8'h5A;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_MISS  = 2'b10,
    CELL_HIT   = 2'b11
  } cell_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CALC,
    ST_READ,
    ST_WAIT,
    ST_EVAL,
    ST_WRITE,
    ST_DONE,
    ST_OVER
  } shot_state_e;

  typedef enum logic [1:0] {
    P2C_IDLE,
    P2C_CHECK,
    P2C_CALC
  } p2c_phase_e;

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/pix_to_cell.sv
// Pixel-to-cell converter: grid range check, iterative division by CELL_SIZE,
// and row*GRID_N+col address generation, driven by a start/done handshake.
module pix_to_cell
  import sea_battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       err_o,
  output logic       done_o,
  output logic [6:0] addr_o
);

  localparam logic [9:0] X_LO = 10'(GRID_X);
  localparam logic [9:0] X_HI = 10'(GRID_X_END);
  localparam logic [9:0] Y_LO = 10'(GRID_Y);
  localparam logic [9:0] Y_HI = 10'(GRID_Y_END);
  localparam logic [9:0] CELL = 10'(CELL_SIZE);

  p2c_phase_e phase_q, phase_d;
  logic [9:0] rx_q, rx_d;
  logic [9:0] ry_q, ry_d;
  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;

  // NOTE: reset is synchronous, so it lives inside the clocked branch; sequential
  // state is updated only with non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= P2C_IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      phase_q <= phase_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    phase_d = phase_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    col_d   = col_q;
    row_d   = row_q;
    err_o   = 1'b0;
    done_o  = 1'b0;

    case (phase_q)
      P2C_IDLE: begin
        if (start_i) begin
          rx_d    = x_i;
          ry_d    = y_i;
          phase_d = P2C_CHECK;
        end
      end
      P2C_CHECK: begin
        if (rx_q < X_LO || rx_q >= X_HI || ry_q < Y_LO || ry_q >= Y_HI) begin
          err_o   = 1'b1;
          phase_d = P2C_IDLE;
        end else begin
          rx_d    = rx_q - X_LO;
          ry_d    = ry_q - Y_LO;
          col_d   = '0;
          row_d   = '0;
          phase_d = P2C_CALC;
        end
      end
      P2C_CALC: begin
        // X and Y divide independently; the longer one sets the duration.
        if (rx_q >= CELL) begin
          rx_d  = rx_q - CELL;
          col_d = col_q + 4'd1;
        end
        if (ry_q >= CELL) begin
          ry_d  = ry_q - CELL;
          row_d = row_q + 4'd1;
        end
        if (rx_q < CELL && ry_q < CELL) begin
          done_o  = 1'b1;
          phase_d = P2C_IDLE;
        end
      end
      default: phase_d = P2C_IDLE;
    endcase
  end

  generate
    if (GRID_N == 10) begin : g_shift_add
      assign addr_o = 7'({row_q, 3'b000}) + 7'({row_q, 1'b0}) + 7'(col_q);
    end else begin : g_mul
      assign addr_o = 7'(32'(row_q) * GRID_N + 32'(col_q));
    end
  endgenerate

endmodule

// File: rtl/shot_controller.sv
// Sea-battle fire sequencer: locate cursor cell, read board RAM, classify, write back, score.
// Optional SHOT_STATS_EN adds shot_count/miss_count outputs.
module shot_controller
  import sea_battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  input  logic [9:0] cursor_x,
  input  logic [9:0] cursor_y,
  output logic [6:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [1:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [1:0] mem_wr_data,
  output logic       busy,
  output logic       cursor_lock,
  output logic       shot_done,
  output logic       shot_hit,
  output logic       shot_repeat,
  output logic       shot_err,
  output logic [4:0] hit_count,
  output logic       game_over
`ifdef SHOT_STATS_EN
  ,
  output logic [6:0] shot_count,
  output logic [6:0] miss_count
`endif
);

  localparam logic [4:0] HIT_MAX = 5'(SHIP_CELLS);

  shot_state_e state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  cell_e       wr_data_q, wr_data_d;
  logic        hit_q, hit_d;
  logic        rep_q, rep_d;
  logic [4:0]  hit_count_q, hit_count_d;

  logic        p2c_start;
  logic        p2c_err;
  logic        p2c_done;
  logic [6:0]  p2c_addr;
  logic        rd_en;
  logic        wr_en;
  logic        done;
  logic        err;

  pix_to_cell u_pix_to_cell (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (p2c_start),
    .x_i     (cursor_x),
    .y_i     (cursor_y),
    .err_o   (p2c_err),
    .done_o  (p2c_done),
    .addr_o  (p2c_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_data_q   <= CELL_EMPTY;
      hit_q       <= 1'b0;
      rep_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      hit_q       <= hit_d;
      rep_q       <= rep_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    hit_d       = hit_q;
    rep_d       = rep_q;
    hit_count_d = hit_count_q;
    p2c_start   = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_code == KEY_FIRE) begin
          p2c_start = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (p2c_err) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (p2c_done) begin
          addr_d  = p2c_addr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: state_d = ST_EVAL;
      ST_EVAL: begin
        case (cell_e'(mem_rd_data))
          CELL_EMPTY: begin
            wr_data_d = CELL_MISS;
            hit_d     = 1'b0;
            rep_d     = 1'b0;
            state_d   = ST_WRITE;
          end
          CELL_SHIP: begin
            wr_data_d = CELL_HIT;
            hit_d     = 1'b1;
            rep_d     = 1'b0;
            if (hit_count_q != HIT_MAX) hit_count_d = hit_count_q + 5'd1;
            state_d   = ST_WRITE;
          end
          CELL_MISS, CELL_HIT: begin
            hit_d   = 1'b0;
            rep_d   = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = (hit_count_q == HIT_MAX) ? ST_OVER : ST_IDLE;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write coinciding with the reset edge must not reach the RAM.
  assign mem_wr_en   = wr_en & rst_n;
  assign mem_wr_data = wr_en ? wr_data_q : CELL_EMPTY;
  assign mem_rd_en   = rd_en;
  assign mem_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_OVER);
  assign cursor_lock = busy;
  assign shot_done   = done;
  assign shot_hit    = done & hit_q;
  assign shot_repeat = done & rep_q;
  assign shot_err    = err;
  assign hit_count   = hit_count_q;
  assign game_over   = (state_q == ST_OVER);

`ifdef SHOT_STATS_EN
  logic [6:0] shot_count_q;
  logic [6:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shot_count_q <= '0;
      miss_count_q <= '0;
    end else if (done && !rep_q) begin
      shot_count_q <= sat_inc7(shot_count_q);
      if (!hit_q) miss_count_q <= sat_inc7(miss_count_q);
    end
  end

  assign shot_count = shot_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller with a behavioural single-port board RAM.
module tb_shot_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic [9:0] cursor_x = '0;
  logic [9:0] cursor_y = '0;
  logic [6:0] mem_addr;
  logic       mem_rd_en;
  logic [1:0] mem_rd_data = 2'b00;
  logic       mem_wr_en;
  logic [1:0] mem_wr_data;
  logic       busy, cursor_lock, shot_done, shot_hit, shot_repeat, shot_err;
  logic [4:0] hit_count;
  logic       game_over;
`ifdef SHOT_STATS_EN
  logic [6:0] shot_count, miss_count;
`endif

  shot_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .cursor_lock (cursor_lock),
    .shot_done   (shot_done),
    .shot_hit    (shot_hit),
    .shot_repeat (shot_repeat),
    .shot_err    (shot_err),
    .hit_count   (hit_count),
    .game_over   (game_over)
`ifdef SHOT_STATS_EN
    ,
    .shot_count  (shot_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Board RAM model: registered read, one-cycle latency; bench-side load/clear port.
  logic [1:0] ram [100];
  logic       ld_en = 1'b0, ld_clr = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [1:0] ld_val = '0;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 100; i++) ram[i] <= 2'b00;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_val;
    end else begin
      if (mem_rd_en) mem_rd_data <= ram[mem_addr];
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    end
  end

  int overlap = 0;
  always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap++;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic poke(input int a, input logic [1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 7'(a); ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_ram();
    @(negedge clk); ld_clr = 1'b1;
    @(negedge clk); ld_clr = 1'b0;
  endtask

  int busy_cyc, rd_cnt, wr_cnt, done_cnt, err_cnt, first_rd;
  logic [6:0] rd_addr, wr_addr;
  logic [1:0] wr_val;
  logic       hit_v, rep_v;

  task automatic press(input int x, input int y, input logic [7:0] code);
    @(negedge clk);
    cursor_x = 10'(x); cursor_y = 10'(y); key_code = code; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_code = 8'h00;
  endtask

  // Fire one key and observe the controller until it is no longer busy.
  task automatic shoot(input int x, input int y, input logic [7:0] code);
    busy_cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; first_rd = -1;
    rd_addr = '0; wr_addr = '0; wr_val = '0; hit_v = 1'b0; rep_v = 1'b0;
    press(x, y, code);
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cyc++;
      if (mem_rd_en) begin
        rd_cnt++; rd_addr = mem_addr;
        if (first_rd < 0) first_rd = c;
      end
      if (mem_wr_en) begin
        wr_cnt++; wr_addr = mem_addr; wr_val = mem_wr_data;
      end
      if (shot_done) begin
        done_cnt++; hit_v = shot_hit; rep_v = shot_repeat;
      end
      if (shot_err) err_cnt++;
      if (!busy) break;
      @(negedge clk);
    end
    check("shot_terminates", busy, 0);
  endtask

  initial begin
    // Reset state
    clear_ram();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_lock", cursor_lock, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_done", shot_done, 0);
    check("rst_err", shot_err, 0);
    check("rst_hits", hit_count, 0);
    check("rst_over", game_over, 0);
    check("rst_addr", mem_addr, 0);
    rst_n = 1'b1;

    // Hit at the grid origin
    poke(0, 2'b01);
    poke(99, 2'b00);
    shoot(320, 50, 8'h5A);
    check("t1_calc_cycles", first_rd - 1, 1);
    check("t1_rd_cnt", rd_cnt, 1);
    check("t1_rd_addr", rd_addr, 0);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_wr_addr", wr_addr, 0);
    check("t1_wr_data", wr_val, 3);
    check("t1_done", done_cnt, 1);
    check("t1_hit", hit_v, 1);
    check("t1_repeat", rep_v, 0);
    check("t1_hit_count", hit_count, 1);
    check("t1_ram0", ram[0], 3);

    // Miss at the last cell
    shoot(590, 320, 8'h5A);
    check("t2_calc_cycles", first_rd - 1, 10);
    check("t2_rd_addr", rd_addr, 99);
    check("t2_wr_cnt", wr_cnt, 1);
    check("t2_wr_addr", wr_addr, 99);
    check("t2_wr_data", wr_val, 2);
    check("t2_done", done_cnt, 1);
    check("t2_hit", hit_v, 0);
    check("t2_ram99", ram[99], 2);

    // Repeat shot on the same cell
    shoot(590, 320, 8'h5A);
    check("t3_rd_cnt", rd_cnt, 1);
    check("t3_wr_cnt", wr_cnt, 0);
    check("t3_done", done_cnt, 1);
    check("t3_repeat", rep_v, 1);
    check("t3_hit", hit_v, 0);
    check("t3_hit_count", hit_count, 1);

    // Out-of-grid shots, including the first pixel past each far edge
    shoot(300, 50, 8'h5A);
    check("t4_err", err_cnt, 1);
    check("t4_busy_cycles", busy_cyc, 1);
    check("t4_rd_cnt", rd_cnt, 0);
    check("t4_wr_cnt", wr_cnt, 0);
    check("t4_done", done_cnt, 0);
    shoot(620, 60, 8'h5A);
    check("t5_err_xmax", err_cnt, 1);
    shoot(400, 350, 8'h5A);
    check("t5_err_ymax", err_cnt, 1);
    check("t5_rd_cnt", rd_cnt, 0);

    // Last in-grid pixel floors to cell 99
    shoot(619, 349, 8'h5A);
    check("t6_err", err_cnt, 0);
    check("t6_calc_cycles", first_rd - 1, 10);
    check("t6_rd_addr", rd_addr, 99);
    check("t6_repeat", rep_v, 1);

    // Non-fire key is ignored
    shoot(400, 100, 8'h1C);
    check("t7_busy_cycles", busy_cyc, 0);
    check("t7_rd_cnt", rd_cnt, 0);

    // Reset during CALC
    press(590, 320, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    check("t8_busy_in_calc", busy, 1);
    check("t8_hits_before", hit_count, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t8_busy", busy, 0);
    check("t8_hits", hit_count, 0);
    check("t8_rd_en", mem_rd_en, 0);

    // Reset in the WRITE cycle drops the write
    poke(11, 2'b01);
    press(350, 80, 8'h5A);
    for (int c = 0; c < 30; c++) begin
      if (mem_wr_en) break;
      @(negedge clk);
    end
    check("t9_wr_reached", mem_wr_en, 1);
    check("t9_wr_addr", mem_addr, 11);
    check("t9_hits_before", hit_count, 1);
    rst_n = 1'b0;
    #1;
    check("t9_wr_gated", mem_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t9_busy", busy, 0);
    check("t9_hits", hit_count, 0);
    check("t9_wr_en", mem_wr_en, 0);
    check("t9_ram11", ram[11], 1);

    // Sink all 20 ships (cells 0..19), off-centre pixels
    clear_ram();
    for (int i = 0; i < 20; i++) poke(i, 2'b01);
    for (int i = 0; i < 20; i++) begin
      shoot(320 + 30 * (i % 10) + 15, 50 + 30 * (i / 10) + 7, 8'h5A);
      check($sformatf("t10_addr_%0d", i), rd_addr, i);
      check($sformatf("t10_hits_%0d", i), hit_count, i + 1);
      check($sformatf("t10_over_%0d", i), game_over, (i == 19) ? 1 : 0);
    end
    check("t10_busy_over", busy, 0);
    shoot(335, 57, 8'h5A);
    check("t11_busy_cycles", busy_cyc, 0);
    check("t11_rd_cnt", rd_cnt, 0);
    check("t11_done", done_cnt, 0);
    check("t11_over", game_over, 1);
    check("t11_hits", hit_count, 20);
`ifdef SHOT_STATS_EN
    check("stats_shots", shot_count, 20);
    check("stats_misses", miss_count, 0);
`endif

    check("rd_wr_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
